mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 170 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one bus access per instruction,
// with alignment traps, a 16-cycle bus timeout and flush handling.
module mem_access_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic [1:0]  EX_MEM_Size,
  input  logic        EX_MEM_Unsigned,
  input  logic [31:0] EX_MEM_ALU_result,
  input  logic [31:0] EX_MEM_rt_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic [31:0] MEM_MemorIOData,
  output logic        mem_stall,
  output logic        MEM_AdEL,
  output logic        MEM_AdES,
  output logic        MEM_BusErr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic        r_uns;
  logic        r_load;
  logic        r_flushed;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_data;
  logic        r_buserr;

  logic        w_align;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_act;
  logic        w_start;
  logic        w_mis;
  logic [31:0] w_sh;
  logic [31:0] w_ld;
  logic [1:0]  w_a;

  assign w_a = EX_MEM_ALU_result[1:0];

  always_comb begin
    w_align = 1'b1;
    w_be    = 4'b1111;
    w_wdata = EX_MEM_rt_data;
    case (EX_MEM_Size)
      2'b00: begin
        w_be    = 4'b0001 << w_a;
        w_wdata = {4{EX_MEM_rt_data[7:0]}};
      end
      2'b01: begin
        w_align = ~w_a[0];
        w_be    = w_a[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{EX_MEM_rt_data[15:0]}};
      end
      default: w_align = (w_a == 2'b00);
    endcase
  end

  // Only IDLE accepts work; reset and flush gate traps too.
  assign w_act   = reset & ~flush & (r_state == S_IDLE)
                 & (EX_MEM_MemRead | EX_MEM_MemWrite);
  assign w_start = w_act & w_align;
  assign w_mis   = w_act & ~w_align;

  assign w_sh = bus_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ld = w_sh;
    case (r_size)
      2'b00:
        w_ld = {{24{~r_uns & w_sh[7]}}, w_sh[7:0]};
      2'b01:
        w_ld = {{16{~r_uns & w_sh[15]}}, w_sh[15:0]};
      default: w_ld = w_sh;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_size    <= 2'b00;
      r_off     <= 2'b00;
      r_uns     <= 1'b0;
      r_load    <= 1'b0;
      r_flushed <= 1'b0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_be      <= 4'b0000;
      r_data    <= 32'd0;
      r_buserr  <= 1'b0;
    end else begin
      r_buserr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state   <= S_WAIT;
            r_cnt     <= 4'd0;
            r_flushed <= 1'b0;
            r_size    <= EX_MEM_Size;
            r_off     <= w_a;
            r_uns     <= EX_MEM_Unsigned;
            r_load    <= EX_MEM_MemRead;
            r_req     <= 1'b1;
            r_we      <= ~EX_MEM_MemRead;
            r_addr    <= {EX_MEM_ALU_result[31:2], 2'b00};
            r_be      <= w_be;
            r_wdata   <= EX_MEM_MemRead ? 32'd0 : w_wdata;
          end
        end
        S_WAIT: begin
          if (flush)
            r_flushed <= 1'b1;
          if (bus_ready) begin
            r_req <= 1'b0;
            // A squashed access still finishes the handshake.
            if (r_flushed | flush) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DONE;
              if (r_load)
                r_data <= w_ld;
            end
          end else if (r_cnt == 4'd15) begin
            r_req    <= 1'b0;
            r_buserr <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_req         = r_req;
  assign bus_we          = r_we;
  assign bus_addr        = r_addr;
  assign bus_wdata       = r_wdata;
  assign bus_be          = r_be;
  assign MEM_MemorIOData = r_data;
  assign MEM_BusErr      = r_buserr;
  assign mem_stall       = w_start | (r_state == S_WAIT);
  assign MEM_AdEL        = w_mis & EX_MEM_MemRead;
  assign MEM_AdES        = w_mis & ~EX_MEM_MemRead;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against an
// arithmetic model of lanes, alignment and load extension.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        EX_MEM_MemRead;
  logic        EX_MEM_MemWrite;
  logic [1:0]  EX_MEM_Size;
  logic        EX_MEM_Unsigned;
  logic [31:0] EX_MEM_ALU_result;
  logic [31:0] EX_MEM_rt_data;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic [31:0] MEM_MemorIOData;
  logic        mem_stall;
  logic        MEM_AdEL;
  logic        MEM_AdES;
  logic        MEM_BusErr;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] last_data = 32'd0;

  mem_access_unit dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .EX_MEM_MemRead(EX_MEM_MemRead),
    .EX_MEM_MemWrite(EX_MEM_MemWrite),
    .EX_MEM_Size(EX_MEM_Size),
    .EX_MEM_Unsigned(EX_MEM_Unsigned),
    .EX_MEM_ALU_result(EX_MEM_ALU_result),
    .EX_MEM_rt_data(EX_MEM_rt_data),
    .bus_req(bus_req),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_be(bus_be),
    .bus_ready(bus_ready),
    .bus_rdata(bus_rdata),
    .MEM_MemorIOData(MEM_MemorIOData),
    .mem_stall(mem_stall),
    .MEM_AdEL(MEM_AdEL),
    .MEM_AdES(MEM_AdES),
    .MEM_BusErr(MEM_BusErr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] a,
                                        input logic [1:0] s);
    int v;
    v = ((1 << nbytes(s)) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] exp_wd(input logic [31:0] rt,
                                         input logic [1:0] s);
    if (nbytes(s) == 1) return (rt % 256) * 32'h0101_0101;
    if (nbytes(s) == 2) return (rt % 65536) * 32'h0001_0001;
    return rt;
  endfunction

  function automatic logic [31:0] exp_ld(input logic [31:0] rd,
    input logic [31:0] a, input logic [1:0] s, input bit u);
    longint v;
    longint m;
    v = rd;
    v = v >> (8 * (a % 4));
    m = 64'd1 << (8 * nbytes(s));
    v = v % m;
    if (!u && v >= m / 2) v = v - m;
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    EX_MEM_MemRead  = 1'b0;
    EX_MEM_MemWrite = 1'b0;
    EX_MEM_ALU_result = $urandom;
    EX_MEM_rt_data  = $urandom;
    EX_MEM_Size     = 2'($urandom);
    EX_MEM_Unsigned = 1'($urandom);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called at posedge+1 with the unit in IDLE; returns the same way.
  task automatic xact(input bit rd, input logic [1:0] sz, input bit u,
    input logic [31:0] a, input logic [31:0] rt,
    input logic [31:0] rdat, input int lat, input int fl_at);
    bit al;
    bit fl;
    al = (a % nbytes(sz)) == 0;
    fl = 0;
    EX_MEM_MemRead  = rd;
    EX_MEM_MemWrite = !rd;
    EX_MEM_Size     = sz;
    EX_MEM_Unsigned = u;
    EX_MEM_ALU_result = a;
    EX_MEM_rt_data  = rt;
    flush = 1'b0;
    bus_ready = 1'b0;
    @(negedge clock);
    chk("req_stall", 32'(mem_stall), 32'(al));
    chk("adel", 32'(MEM_AdEL), 32'(rd && !al));
    chk("ades", 32'(MEM_AdES), 32'(!rd && !al));
    chk("req_idle", 32'(bus_req), 32'd0);
    step();
    idle_inputs();
    if (!al) return;
    for (int i = 0; i <= lat; i++) begin
      bus_ready = (i == lat);
      bus_rdata = (i == lat) ? rdat : $urandom;
      flush = (i == fl_at);
      if (i == fl_at) fl = 1;
      @(negedge clock);
      chk("w_req", 32'(bus_req), 32'd1);
      chk("w_stall", 32'(mem_stall), 32'd1);
      chk("w_addr", bus_addr, a & ~32'd3);
      chk("w_be", 32'(bus_be), 32'(exp_be(a, sz)));
      chk("w_we", 32'(bus_we), 32'(!rd));
      chk("w_wdata", bus_wdata, rd ? 32'd0 : exp_wd(rt, sz));
      step();
    end
    bus_ready = 1'b0;
    flush = 1'b0;
    if (rd && !fl) last_data = exp_ld(rdat, a, sz, u);
    @(negedge clock);
    chk("d_stall", 32'(mem_stall), 32'd0);
    chk("d_req", 32'(bus_req), 32'd0);
    chk("d_data", MEM_MemorIOData, last_data);
    step();
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    bus_ready = 1'b0;
    bus_rdata = 32'd0;
    idle_inputs();
    EX_MEM_MemRead = 1'b1;
    EX_MEM_Size = 2'b10;
    EX_MEM_ALU_result = 32'h0000_3001;
    step();
    @(negedge clock);
    chk("rst_adel", 32'(MEM_AdEL), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_data", MEM_MemorIOData, 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    step();
    reset = 1'b1;
    idle_inputs();
    step();

    xact(1, 2'b00, 0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1, -1);
    chk("byte_sx", MEM_MemorIOData, 32'hFFFF_FF80);
    xact(0, 2'b01, 0, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 0, -1);
    xact(1, 2'b10, 0, 32'h0000_3001, 32'h0, 32'h0, 0, -1);
    xact(1, 2'b10, 1, 32'h0000_4000, 32'h0, 32'h5555_AAAA, 2, 1);
    chk("flush_keep", MEM_MemorIOData, 32'hFFFF_FF80);
    xact(1, 2'b01, 1, 32'h0000_5002, 32'h0, 32'hBEEF_0001, 15, -1);
    chk("ready_wins", MEM_MemorIOData, 32'h0000_BEEF);

    // flush in IDLE suppresses the trap and the access
    flush = 1'b1;
    EX_MEM_MemWrite = 1'b1;
    EX_MEM_Size = 2'b01;
    EX_MEM_ALU_result = 32'h0000_0011;
    @(negedge clock);
    chk("fl_ades", 32'(MEM_AdES), 32'd0);
    chk("fl_stall", 32'(mem_stall), 32'd0);
    step();
    flush = 1'b0;
    idle_inputs();
    @(negedge clock);
    chk("fl_req", 32'(bus_req), 32'd0);
    step();

    // timeout: bus never answers
    EX_MEM_MemRead = 1'b1;
    EX_MEM_Size = 2'b10;
    EX_MEM_ALU_result = 32'h0000_6000;
    step();
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      chk("to_req", 32'(bus_req), 32'd1);
      chk("to_err0", 32'(MEM_BusErr), 32'd0);
      step();
    end
    @(negedge clock);
    chk("to_err", 32'(MEM_BusErr), 32'd1);
    chk("to_req0", 32'(bus_req), 32'd0);
    chk("to_stall", 32'(mem_stall), 32'd0);
    chk("to_data", MEM_MemorIOData, last_data);
    step();
    @(negedge clock);
    chk("to_pulse", 32'(MEM_BusErr), 32'd0);
    step();

    for (int k = 0; k < 60; k++) begin
      logic [1:0] sz;
      int lat;
      int fa;
      sz  = 2'($urandom);
      lat = $urandom_range(0, 3);
      fa  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, lat) : -1;
      xact(1'($urandom), sz, 1'($urandom), $urandom, $urandom,
           $urandom, lat, fa);
    end

    // reset while waiting abandons the access
    EX_MEM_MemWrite = 1'b1;
    EX_MEM_Size = 2'b10;
    EX_MEM_ALU_result = 32'h0000_7000;
    EX_MEM_rt_data = 32'hCAFE_F00D;
    step();
    idle_inputs();
    step();
    reset = 1'b0;
    step();
    @(negedge clock);
    chk("mr_req", 32'(bus_req), 32'd0);
    chk("mr_stall", 32'(mem_stall), 32'd0);
    chk("mr_we", 32'(bus_we), 32'd0);
    chk("mr_wdata", bus_wdata, 32'd0);
    chk("mr_addr", bus_addr, 32'd0);
    chk("mr_be", 32'(bus_be), 32'd0);
    chk("mr_data", MEM_MemorIOData, 32'd0);
    chk("mr_err", 32'(MEM_BusErr), 32'd0);
    step();
    reset = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
